aes_cp_sequencer: RTL and testbench

- Hardware master that drives the 4-bit register port of aes256_coprocessor, so that a streaming datapath can encrypt/decrypt 128-bit blocks without CPU register pokes.
- Accepts a 128-bit block on a valid/ready input, programs key/nonce when requested, loads four data words and sets run.
- Waits for the coprocessor interrupt, drains four result words and presents the 128-bit result on a valid/ready output.

---
 rtl/aes_cp_pkg.sv | 29 ++
 rtl/aes_cp_sequencer.sv | 157 +++++++++++++++
 tb/tb_aes_cp_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_cp_pkg.sv
// Shared constants and types for the AES coprocessor sequencer: the
// coprocessor register map, the status-register bits and the sequencer states.
package aes_cp_pkg;

  localparam logic [3:0] CP_STATUS = 4'd0;
  localparam logic [3:0] CP_NONCE0 = 4'd1;
  localparam logic [3:0] CP_KEY0   = 4'd5;
  localparam logic [3:0] CP_DIN    = 4'd13;
  localparam logic [3:0] CP_DOUT   = 4'd14;

  // Status bits; prefixed so they do not collide with the RUN state below.
  localparam logic [31:0] CP_RUN = 32'h0000_0001;
  localparam logic [31:0] CP_RST = 32'h0000_0002;

  typedef enum logic [3:0] {
    IDLE, CPRST, KEY, NONCE, DATA, RUN, WAIT, READ, OUT
  } state_t;

  // Number of coprocessor transactions in each fixed-length phase.
  localparam logic [2:0] LEN_CPRST = 3'd2;
  localparam logic [2:0] LEN_KEY   = 3'd0;  // 8 words: wraps at 7
  localparam logic [2:0] LEN_QUAD  = 3'd4;

  // True on the last word of a phase with `len` words (0 encodes 8).
  function automatic logic phase_last(input logic [2:0] word, input logic [2:0] len);
    return word == (len - 3'd1);
  endfunction

endpackage

// File: rtl/aes_cp_sequencer.sv
// Streams 128-bit blocks through aes256_coprocessor via its 4-bit register
// port: optional reset and key/nonce load, data load, run, wait, drain.
module aes_cp_sequencer
  import aes_cp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [255:0] cfg_key,
  input  logic [127:0] cfg_nonce,
  input  logic         in_valid,
  input  logic         in_load,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         timeout_err,
  output logic [3:0]   cp_addr,
  output logic [31:0]  cp_data_in,
  output logic         cp_write_en,
  input  logic [31:0]  cp_data_out,
  input  logic         cp_interrupt
);

  state_t                 state_reg, state_next;
  logic [2:0]             word_reg, word_next;
  logic [TIMEOUT_W-1:0]   tcnt_reg, tcnt_next;
  logic [255:0]           key_reg;
  logic [127:0]           nonce_reg, block_reg;
  logic [3:0]             addr_next;
  logic [31:0]            wdata_next;
  logic                   we_next;
  logic                   accept, timeout_hit;
  logic [255:0]           key_lat;
  logic [127:0]           nonce_lat, block_lat;

  assign accept      = (state_reg == IDLE) && in_valid;
  assign timeout_hit = (state_reg == WAIT) && !cp_interrupt &&
                       (tcnt_reg == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);

  // Outputs are registered, so the write mux must already see the values
  // being latched on the accept edge.
  assign key_lat   = accept ? cfg_key   : key_reg;
  assign nonce_lat = accept ? cfg_nonce : nonce_reg;
  assign block_lat = accept ? in_data   : block_reg;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      tcnt_reg    <= '0;
      key_reg     <= '0;
      nonce_reg   <= '0;
      block_reg   <= '0;
      cp_addr     <= '0;
      cp_data_in  <= '0;
      cp_write_en <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      tcnt_reg    <= tcnt_next;
      cp_addr     <= addr_next;
      cp_data_in  <= wdata_next;
      cp_write_en <= we_next;
      out_valid   <= (state_next == OUT);
      key_reg     <= key_lat;
      nonce_reg   <= nonce_lat;
      block_reg   <= block_lat;
      if (accept)
        timeout_err <= 1'b0;
      else if (timeout_hit)
        timeout_err <= 1'b1;
      if (state_reg == READ)
        out_data[{word_reg[1:0], 5'd0} +: 32] <= cp_data_out;
    end
  end

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg + 3'd1;
    tcnt_next  = tcnt_reg;
    case (state_reg)
      IDLE: begin
        word_next = '0;
        if (in_valid) state_next = in_load ? CPRST : DATA;
      end
      CPRST: if (phase_last(word_reg, LEN_CPRST)) begin state_next = KEY;   word_next = '0; end
      KEY:   if (phase_last(word_reg, LEN_KEY))   begin state_next = NONCE; word_next = '0; end
      NONCE: if (phase_last(word_reg, LEN_QUAD))  begin state_next = DATA;  word_next = '0; end
      DATA:  if (phase_last(word_reg, LEN_QUAD))  begin state_next = RUN;   word_next = '0; end
      RUN: begin
        state_next = WAIT;
        word_next  = '0;
        tcnt_next  = '0;
      end
      WAIT: begin
        word_next = '0;
        if (cp_interrupt)     state_next = READ;
        else if (timeout_hit) state_next = IDLE;
        else                  tcnt_next  = tcnt_reg + 1'b1;
      end
      READ:  if (phase_last(word_reg, LEN_QUAD))  begin state_next = OUT;   word_next = '0; end
      OUT: begin
        word_next = '0;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        word_next  = '0;
      end
    endcase
  end

  // Register-port transaction for the coming cycle, keyed on the next state.
  always_comb begin
    addr_next  = CP_STATUS;
    wdata_next = '0;
    we_next    = 1'b0;
    case (state_next)
      CPRST: begin
        we_next    = 1'b1;
        wdata_next = (word_next == 3'd0) ? CP_RST : 32'h0;
      end
      KEY: begin
        we_next    = 1'b1;
        addr_next  = CP_KEY0 + {1'b0, word_next};
        wdata_next = key_lat[{word_next, 5'd0} +: 32];
      end
      NONCE: begin
        we_next    = 1'b1;
        addr_next  = CP_NONCE0 + {2'b00, word_next[1:0]};
        wdata_next = nonce_lat[{word_next[1:0], 5'd0} +: 32];
      end
      DATA: begin
        we_next    = 1'b1;
        addr_next  = CP_DIN;
        wdata_next = block_lat[{word_next[1:0], 5'd0} +: 32];
      end
      RUN: begin
        we_next    = 1'b1;
        wdata_next = CP_RUN;
      end
      READ:    addr_next = CP_DOUT;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_cp_sequencer.sv
// Bench for aes_cp_sequencer: a toy symmetric coprocessor model, a vector
// table with randomized entries, and hand sequences for timeout and reset.
module tb_aes_cp_sequencer;

  localparam int TO = 16;
  localparam int NV = 14;
  localparam int LOGN = 1024;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_nonce = '0;
  logic         in_valid = 1'b0;
  logic         in_load = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         timeout_err;
  logic [3:0]   cp_addr;
  logic [31:0]  cp_data_in;
  logic         cp_write_en;
  logic [31:0]  cp_data_out;
  logic         cp_interrupt;

  aes_cp_sequencer #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(5)) dut (
    .clock(clock), .rst(rst), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .in_valid(in_valid), .in_load(in_load), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err),
    .cp_addr(cp_addr), .cp_data_in(cp_data_in), .cp_write_en(cp_write_en),
    .cp_data_out(cp_data_out), .cp_interrupt(cp_interrupt)
  );

  always #5 clock = ~clock;

  // ---------------- coprocessor model ----------------
  // Toy cipher: out word i = din i ^ key i ^ key i+4 ^ nonce i ^ A5A5A5A5.
  logic [31:0] m_key [8];
  logic [31:0] m_nonce [4];
  logic [31:0] m_din [4];
  logic [31:0] m_dout [4];
  logic [2:0]  m_din_n = 3'd0;
  logic [2:0]  m_rd = 3'd4;
  logic        m_irq = 1'b0;
  int          m_cnt = 0;
  int          irq_delay = 0;
  int          log_n = 0;
  int          pops = 0;
  logic [3:0]  log_addr [LOGN];
  logic [31:0] log_data [LOGN];

  assign cp_data_out  = (m_rd < 3'd4) ? m_dout[m_rd[1:0]] : 32'hDEAD_BEEF;
  assign cp_interrupt = m_irq;

  always @(posedge clock) begin
    if (cp_write_en) begin
      log_addr[log_n % LOGN] <= cp_addr;
      log_data[log_n % LOGN] <= cp_data_in;
      log_n <= log_n + 1;
      if (cp_addr == 4'd0) begin
        if (cp_data_in[1]) begin
          m_din_n <= 3'd0; m_rd <= 3'd4; m_irq <= 1'b0; m_cnt <= 0;
        end else if (cp_data_in[0]) begin
          for (int i = 0; i < 4; i++)
            m_dout[i] <= m_din[i] ^ m_key[i] ^ m_key[i+4] ^ m_nonce[i] ^ 32'hA5A5_A5A5;
          m_din_n <= 3'd0;
          m_rd <= 3'd0;
          if (irq_delay == 0) begin m_irq <= 1'b1; m_cnt <= 0; end
          else begin m_irq <= 1'b0; m_cnt <= irq_delay; end
        end
      end else if (cp_addr <= 4'd4) begin
        m_nonce[int'(cp_addr) - 1] <= cp_data_in;
      end else if (cp_addr <= 4'd12) begin
        m_key[int'(cp_addr) - 5] <= cp_data_in;
      end else if (cp_addr == 4'd13) begin
        if (m_din_n < 3'd4) begin
          m_din[m_din_n[1:0]] <= cp_data_in;
          m_din_n <= m_din_n + 3'd1;
        end
      end
    end else begin
      if (cp_addr == 4'd14) begin
        pops <= pops + 1;
        if (m_rd < 3'd4) m_rd <= m_rd + 3'd1;
      end
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else if (m_cnt == 1) begin m_cnt <= 0; m_irq <= 1'b1; end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    bit           load;
    logic [255:0] key;
    logic [127:0] nonce;
    logic [127:0] data;
    int           delay;
    int           hold;
    logic [127:0] exp_data;
    int           exp_lat;
  } vec_t;

  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;

  vec_t         vecs [NV];
  int           n_vec = 0;
  int           n_fail = 0;
  logic [255:0] cur_key;
  logic [127:0] cur_nonce;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] r256();
    return {r128(), r128()};
  endfunction

  // Reference: the coprocessor remembers the last loaded key/nonce; the
  // toy cipher is an XOR with a keystream derived from them.
  function automatic vec_t mk(input bit load, input logic [255:0] key, input logic [127:0] nonce,
                              input logic [127:0] data, input int delay, input int hold);
    vec_t v;
    v.load = load; v.key = key; v.nonce = nonce; v.data = data;
    v.delay = delay; v.hold = hold;
    if (load) begin cur_key = key; cur_nonce = nonce; end
    v.exp_data = data ^ cur_key[127:0] ^ cur_key[255:128] ^ cur_nonce ^ {4{32'hA5A5_A5A5}};
    v.exp_lat  = 1 + 4 + 1 + (delay + 1) + 4 + (load ? 14 : 0);
    return v;
  endfunction

  task automatic drive_accept(input bit load, input logic [255:0] key, input logic [127:0] nonce,
                              input logic [127:0] data);
    cfg_key   = load ? key : r256();
    cfg_nonce = load ? nonce : r128();
    in_valid  = 1'b1;
    in_load   = load;
    in_data   = data;
    tick();
    in_valid  = 1'b0;
    in_load   = 1'b0;
    in_data   = r128();
    cfg_key   = r256();
    cfg_nonce = r128();
  endtask

  task automatic apply_block(input vec_t v, input int idx);
    int  lstart, pstart, cyc;
    wr_t e[$];
    logic [255:0] k;
    logic [127:0] n, d;
    k = v.key; n = v.nonce; d = v.data;
    irq_delay = v.delay;
    chk("idle_in_ready", {in_ready, out_valid}, 2'b10);
    lstart = log_n;
    pstart = pops;
    drive_accept(v.load, v.key, v.nonce, v.data);
    cyc = 1;
    chk("accept_busy_err", {busy, in_ready, timeout_err}, 3'b100);
    while (!out_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, v.exp_lat);
    chk("out_data", out_data, v.exp_data);
    for (int i = 0; i < v.hold; i++) begin
      out_ready = 1'b0;
      tick();
      chk("hold_ctl", {out_valid, in_ready, cp_write_en}, 3'b100);
      chk("hold_data", out_data, v.exp_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handshake", {out_valid, in_ready, busy}, 3'b010);
    if (v.load) begin
      e.push_back('{4'd0, 32'h2});
      e.push_back('{4'd0, 32'h0});
      for (int i = 0; i < 8; i++) e.push_back('{4'(5 + i), k[32*i +: 32]});
      for (int i = 0; i < 4; i++) e.push_back('{4'(1 + i), n[32*i +: 32]});
    end
    for (int i = 0; i < 4; i++) e.push_back('{4'd13, d[32*i +: 32]});
    e.push_back('{4'd0, 32'h1});
    chk("write_count", log_n - lstart, e.size());
    for (int i = 0; i < e.size() && i < log_n - lstart; i++)
      chk($sformatf("write%0d", i), {log_addr[(lstart + i) % LOGN], log_data[(lstart + i) % LOGN]},
          {e[i].a, e[i].d});
    chk("pops", pops - pstart, 4);
    $display("block %0d load=%0d delay=%0d lat=%0d out=%h", idx, v.load, v.delay, cyc, out_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [255:0] k;
    logic seen_ov;

    // Table: fixed corner vectors first, randomized ones after.
    vecs[0] = mk(1, {256{1'b1}}, '0, {128{1'b1}}, 3, 0);
    vecs[1] = mk(0, '0, '0, vecs[0].exp_data, 0, 0);
    vecs[2] = mk(0, '0, '0, r128(), 2, 20);
    vecs[3] = mk(1, r256(), r128(), r128(), 0, 1);
    for (int i = 4; i < NV; i++)
      vecs[i] = mk(bit'($urandom_range(0, 1)), r256(), r128(), r128(),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));

    repeat (3) tick();
    chk("reset_state", {in_ready, busy, out_valid, timeout_err, cp_write_en, cp_addr, cp_data_in},
        {5'b10000, 4'd0, 32'd0});
    chk("reset_out_data", out_data, '0);
    @(negedge clock);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      apply_block(vecs[i], i);
      if (i == 1) chk("roundtrip", out_data, {128{1'b1}});
    end

    // Interrupt never arrives: abort after TO WAIT cycles, no output.
    k = r256();
    v = mk(1, k, r128(), r128(), -1, 0);
    irq_delay = -1;
    drive_accept(1, v.key, v.nonce, v.data);
    seen_ov = 1'b0;
    for (int i = 0; i < 14 + 5 + TO - 1; i++) begin
      tick();
      seen_ov |= out_valid;
    end
    chk("timeout_no_valid", seen_ov, 1'b0);
    chk("timeout_not_yet", {timeout_err, busy}, 2'b01);
    tick();
    chk("timeout_err", {timeout_err, in_ready, busy, out_valid}, 4'b1100);
    repeat (3) tick();
    chk("timeout_sticky", timeout_err, 1'b1);
    $display("timeout block: timeout_err=%0d in_ready=%0d", timeout_err, in_ready);
    apply_block(mk(0, '0, '0, r128(), 1, 0), 100);

    // Asynchronous reset while the fourth key word is being written.
    irq_delay = 2;
    k = r256();
    drive_accept(1, k, r128(), r128());
    repeat (5) tick();
    chk("pre_reset_key3", {cp_write_en, cp_addr, cp_data_in}, {1'b1, 4'd8, k[127:96]});
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_outs", {in_ready, busy, out_valid, timeout_err, cp_write_en, cp_addr, cp_data_in},
        {5'b10000, 4'd0, 32'd0});
    chk("mid_reset_out_data", out_data, '0);
    $display("reset during KEY word 3: cp_addr=%0d busy=%0d", cp_addr, busy);
    @(negedge clock);
    rst = 1'b0;
    tick();
    apply_block(mk(1, r256(), r128(), r128(), 0, 2), 101);
    apply_block(mk(0, '0, '0, r128(), 4, 0), 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
